x_delay_os_mc: RTL

X_DELAY_OS_MC -- requirements
Module: x_delay_os_mc

---
 rtl/x_delay_os_mc.sv | 127 ++++++++++++
 1 files changed

// File: rtl/x_delay_os_mc.sv
// Multi-channel delayed one-shot: each rising edge on d[k] yields a q[k] pulse
// after a per-channel delay, with a shared, programmable pulse width.
module x_delay_os_mc_ch #(
   parameter int MXDLY = 4,
   parameter int MXWID = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             d,
   input  logic [MXDLY-1:0] dly,
   input  logic [MXWID-1:0] wid,
   input  logic             retrig,
   input  logic             clr_missed,
   output logic             q,
   output logic             busy,
   output logic             missed
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DELAY = 2'd1;
   localparam logic [1:0] PULSE = 2'd2;
   localparam logic [MXDLY-1:0] D_ONE = MXDLY'(1);
   localparam logic [MXWID-1:0] W_ONE = MXWID'(1);

   logic             inh, trig;
   logic [MXDLY-1:0] dly_p, dcnt, dcnt_nx;
   logic [MXWID-1:0] wid_p, wcnt, wcnt_nx;
   logic [1:0]       state, state_nx;
   logic             start, discard;

   // Trigger and its operands are captured together at the trigger edge
   assign start   = trig & ((state == IDLE) | retrig);
   assign discard = trig & (state != IDLE) & ~retrig;

   always_comb begin
      state_nx = state;
      dcnt_nx  = dcnt;
      wcnt_nx  = wcnt;
      case (state)
         DELAY: begin
            if (dcnt == D_ONE) begin
               state_nx = PULSE;
               dcnt_nx  = '0;
            end else begin
               dcnt_nx = dcnt - D_ONE;
            end
         end
         PULSE: begin
            if (wcnt == W_ONE) begin
               state_nx = IDLE;
               wcnt_nx  = '0;
            end else begin
               wcnt_nx = wcnt - W_ONE;
            end
         end
         IDLE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (start) begin
         wcnt_nx = (wid_p == '0) ? W_ONE : wid_p;
         if (dly_p != '0) begin
            state_nx = DELAY;
            dcnt_nx  = dly_p;
         end else begin
            state_nx = PULSE;
            dcnt_nx  = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         inh    <= 1'b1;
         trig   <= 1'b0;
         dly_p  <= '0;
         wid_p  <= '0;
         state  <= IDLE;
         dcnt   <= '0;
         wcnt   <= '0;
         q      <= 1'b0;
         busy   <= 1'b0;
         missed <= 1'b0;
      end else begin
         inh    <= d;
         trig   <= d & ~inh;
         dly_p  <= dly;
         wid_p  <= wid;
         state  <= state_nx;
         dcnt   <= dcnt_nx;
         wcnt   <= wcnt_nx;
         q      <= (state_nx == PULSE);
         busy   <= (state_nx != IDLE);
         missed <= (missed & ~clr_missed) | discard;
      end
   end
endmodule

module x_delay_os_mc #(
   parameter int NCH   = 8,
   parameter int MXDLY = 4,
   parameter int MXWID = 3
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NCH-1:0]       d,
   input  logic [NCH*MXDLY-1:0] delay,
   input  logic [MXWID-1:0]     width,
   input  logic                 retrig,
   input  logic                 clr_missed,
   output logic [NCH-1:0]       q,
   output logic [NCH-1:0]       busy,
   output logic [NCH-1:0]       missed
);
   for (genvar k = 0; k < NCH; k++) begin : g_ch
      x_delay_os_mc_ch #(.MXDLY(MXDLY), .MXWID(MXWID)) u_ch (
         .clock      (clock),
         .reset_n    (reset_n),
         .d          (d[k]),
         .dly        (delay[k*MXDLY +: MXDLY]),
         .wid        (width),
         .retrig     (retrig),
         .clr_missed (clr_missed),
         .q          (q[k]),
         .busy       (busy[k]),
         .missed     (missed[k])
      );
   end
endmodule
